// File: rtl/tf_stage_if.sv
// Handshake bundle between the NTT top-level control and the twiddle-factor
// stage sequencer. The sequencer takes the master side; the requester and
// TF_top observers take the slave side.
interface tf_stage_if #(
  parameter int D_width = 4
);
  logic               start;
  logic               stall;
  logic               busy;
  logic               done;
  logic               TF_wen;
  logic               TF_ren;
  logic [D_width-1:0] it_depth_cnt;
  logic [D_width-1:0] l;
  logic               LAST_STAGE;
  logic               tf_valid;

  modport master (
    input  start, stall,
    output busy, done, TF_wen, TF_ren, it_depth_cnt, l, LAST_STAGE, tf_valid
  );

  modport slave (
    output start, stall,
    input  busy, done, TF_wen, TF_ren, it_depth_cnt, l, LAST_STAGE, tf_valid
  );
endinterface

// File: rtl/tf_stage_ctrl.sv
// Per-stage sequencer for TF_top: LOAD (write), RUN (read/iterate with
// stall), DRAIN (pipeline flush), repeated for every stage, then DONE.
// Every output comes straight from a flop; the next-cycle value of each
// output is derived from the next state so that it lines up with the state.
module tf_stage_ctrl #(
  parameter int NUM_STAGE   = 3,
  parameter int DEPTH       = 4,
  parameter int LOAD_CYCLES = 1,
  parameter int PIPE_LAT    = 2,
  parameter int D_width     = 4
) (
  input  logic       clk,
  input  logic       rst,
  tf_stage_if.master bus
);

  localparam int LC_W = $clog2(LOAD_CYCLES) + 1;
  localparam int DR_W = $clog2(PIPE_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LC_W-1:0]     load_cnt_q, load_cnt_d;
  logic [DR_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [D_width-1:0]  it_cnt_q, it_cnt_d;
  logic [D_width-1:0]  l_q, l_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic                last_q, last_d;
  logic [PIPE_LAT-1:0] vld_sr_q, vld_sr_d;

  // Next state, counters and the read enable for the coming cycle.
  // A RUN cycle with ren_q high is an unstalled iteration; stall seen now
  // decides whether the following RUN cycle issues a read.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    it_cnt_d    = it_cnt_q;
    l_d         = l_q;
    ren_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD;
          l_d        = '0;
          load_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == LC_W'(LOAD_CYCLES - 1)) begin
          state_d  = S_RUN;
          it_cnt_d = '0;
          ren_d    = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (ren_q && (it_cnt_q == D_width'(DEPTH - 1))) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          if (ren_q) begin
            it_cnt_d = it_cnt_q + 1'b1;
          end
          ren_d = ~bus.stall;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DR_W'(PIPE_LAT - 1)) begin
          if (l_q == D_width'(NUM_STAGE - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_LOAD;
            l_d        = l_q + 1'b1;
            load_cnt_d = '0;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered status outputs, decoded from the state being entered.
  // LAST_STAGE covers the working phases of the final stage only.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    wen_d  = (state_d == S_LOAD);
    last_d = (l_d == D_width'(NUM_STAGE - 1)) &&
             ((state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DRAIN));
  end

  // Valid delay line: bit gi holds TF_ren from gi+1 cycles ago.
  assign vld_sr_d[0] = ren_q;
  for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_vld
    assign vld_sr_d[gi] = vld_sr_q[gi-1];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      it_cnt_q    <= '0;
      l_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      last_q      <= 1'b0;
      vld_sr_q    <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      it_cnt_q    <= it_cnt_d;
      l_q         <= l_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      last_q      <= last_d;
      vld_sr_q    <= vld_sr_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.TF_wen       = wen_q;
  assign bus.TF_ren       = ren_q;
  assign bus.it_depth_cnt = it_cnt_q;
  assign bus.l            = l_q;
  assign bus.LAST_STAGE   = last_q;
  assign bus.tf_valid     = vld_sr_q[PIPE_LAT-1];

endmodule

// File: tb/tb_tf_stage_ctrl.sv
// Bench for tf_stage_ctrl: a schedule model builds the expected per-cycle
// outputs of each scenario from stage/iteration rules, one process compares
// the DUT against it every cycle, and literal pins anchor key cycles.
module tb_tf_stage_ctrl;

  localparam int NMAX = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tf_stage_if #(.D_width(4)) bus_a ();
  tf_stage_if #(.D_width(4)) bus_b ();

  tf_stage_ctrl #(
    .NUM_STAGE(3), .DEPTH(4), .LOAD_CYCLES(1), .PIPE_LAT(2), .D_width(4)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master)
  );

  tf_stage_ctrl #(
    .NUM_STAGE(1), .DEPTH(1), .LOAD_CYCLES(1), .PIPE_LAT(1), .D_width(4)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master)
  );

  // stimulus tables, indexed by the clock edge that samples them
  bit st_tab [NMAX];
  bit sl_tab [NMAX];
  bit rs_tab [NMAX];

  // expected outputs, indexed by cycle (cycle c = interval after edge c)
  bit exp_busy [NMAX];
  bit exp_done [NMAX];
  bit exp_wen  [NMAX];
  bit exp_ren  [NMAX];
  bit exp_run  [NMAX];
  bit exp_last [NMAX];
  bit exp_vld  [NMAX];
  int exp_cnt  [NMAX];
  int exp_l    [NMAX];

  // literal pins: cycle, signal code, required value
  int pin_cyc[$];
  int pin_sig[$];
  int pin_val[$];

  string nm [8] = '{"busy", "done", "TF_wen", "TF_ren", "it_depth_cnt", "l", "LAST_STAGE", "tf_valid"};

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;
  bit chk   = 1'b0;
  bit sel   = 1'b0;

  // model state
  int gns, gdp, glc, gpl, gn;
  int gc, glv, gcv;
  bit gab;

  task automatic set_idle(input int c);
    exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_wen[c] = 1'b0;
    exp_ren[c]  = 1'b0; exp_run[c]  = 1'b0; exp_last[c] = 1'b0;
    exp_cnt[c]  = gcv;  exp_l[c]    = glv;
  endtask

  // Append one busy cycle to the schedule unless a reset or the window end cuts it.
  task automatic emit(input bit b_wen, input bit b_ren, input bit b_run, input bit b_done);
    if (gab) return;
    if (gc >= gn - 1 || rs_tab[gc]) begin
      gab = 1'b1;
      return;
    end
    gc++;
    exp_busy[gc] = 1'b1;   exp_done[gc] = b_done; exp_wen[gc] = b_wen;
    exp_ren[gc]  = b_ren;  exp_run[gc]  = b_run;
    exp_cnt[gc]  = gcv;    exp_l[gc]    = glv;
    exp_last[gc] = !b_done && (glv == gns - 1);
  endtask

  task automatic build();
    for (int c = 0; c < NMAX; c++) begin
      exp_busy[c] = 0; exp_done[c] = 0; exp_wen[c] = 0; exp_ren[c] = 0;
      exp_run[c] = 0; exp_last[c] = 0; exp_vld[c] = 0; exp_cnt[c] = 0; exp_l[c] = 0;
    end
    gc = 0; glv = 0; gcv = 0;
    set_idle(0);
    while (gc < gn - 1) begin
      if (rs_tab[gc]) begin
        glv = 0; gcv = 0; gc++; set_idle(gc);
      end else if (!st_tab[gc]) begin
        gc++; set_idle(gc);
      end else begin
        gab = 1'b0;
        for (int s = 0; s < gns; s++) begin
          glv = s;
          for (int k = 0; k < glc; k++) emit(1, 0, 0, 0);
          for (int i = 0; i < gdp; i++) begin
            gcv = i;
            if (i > 0) begin
              while (!gab && sl_tab[gc]) emit(0, 0, 1, 0);
            end
            emit(0, 1, 1, 0);
          end
          for (int k = 0; k < gpl; k++) emit(0, 0, 0, 0);
        end
        emit(0, 0, 0, 1);
        if (gc < gn - 1) begin
          if (rs_tab[gc]) begin
            glv = 0; gcv = 0;
          end
          gc++;
          set_idle(gc);
        end
      end
    end
    // tf_valid: read enable seen gpl cycles earlier, unless a reset edge intervened
    for (int c = 0; c < gn; c++) begin
      if (c - gpl >= 0 && exp_ren[c-gpl]) begin
        exp_vld[c] = 1'b1;
        for (int e = c - gpl; e < c; e++) if (rs_tab[e]) exp_vld[c] = 1'b0;
      end
    end
  endtask

  task automatic clear_scn();
    for (int e = 0; e < NMAX; e++) begin
      st_tab[e] = 0; sl_tab[e] = 0; rs_tab[e] = 0;
    end
    pin_cyc.delete(); pin_sig.delete(); pin_val.delete();
  endtask

  task automatic pin(input int c, input int s, input int v);
    pin_cyc.push_back(c); pin_sig.push_back(s); pin_val.push_back(v);
  endtask

  task automatic drive(input bit r, input bit s, input bit st);
    rst = r;
    bus_a.start = s; bus_a.stall = st;
    bus_b.start = s; bus_b.stall = st;
  endtask

  task automatic run_scn(input bit which, input int n);
    chk = 1'b0;
    sel = which;
    gn  = n;
    if (which) begin gns = 1; gdp = 1; glc = 1; gpl = 1; end
    else       begin gns = 3; gdp = 4; glc = 1; gpl = 2; end
    build();
    drive(1, 0, 0);
    @(posedge clk); #1;
    t = 0; chk = 1'b1;
    for (int e = 0; e < n - 1; e++) begin
      drive(rs_tab[e], st_tab[e], sl_tab[e]);
      @(posedge clk); #1;
      t = e + 1;
    end
    @(negedge clk); #1;
    chk = 1'b0;
  endtask

  // Per-cycle comparison against the model, plus literal pins on model and DUT.
  always @(negedge clk) begin
    int got [8];
    int want [8];
    if (chk) begin
      if (sel) begin
        got[0] = int'(bus_b.busy);   got[1] = int'(bus_b.done);
        got[2] = int'(bus_b.TF_wen); got[3] = int'(bus_b.TF_ren);
        got[4] = int'(bus_b.it_depth_cnt); got[5] = int'(bus_b.l);
        got[6] = int'(bus_b.LAST_STAGE);   got[7] = int'(bus_b.tf_valid);
      end else begin
        got[0] = int'(bus_a.busy);   got[1] = int'(bus_a.done);
        got[2] = int'(bus_a.TF_wen); got[3] = int'(bus_a.TF_ren);
        got[4] = int'(bus_a.it_depth_cnt); got[5] = int'(bus_a.l);
        got[6] = int'(bus_a.LAST_STAGE);   got[7] = int'(bus_a.tf_valid);
      end
      want[0] = int'(exp_busy[t]); want[1] = int'(exp_done[t]);
      want[2] = int'(exp_wen[t]);  want[3] = int'(exp_ren[t]);
      want[4] = exp_cnt[t];        want[5] = exp_l[t];
      want[6] = int'(exp_last[t]); want[7] = int'(exp_vld[t]);
      for (int k = 0; k < 8; k++) begin
        if (k == 4 && !exp_run[t]) continue;
        n_cmp++;
        if (got[k] != want[k]) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm[k], sel, t, got[k], want[k]);
        end
      end
      for (int i = 0; i < pin_cyc.size(); i++) begin
        if (pin_cyc[i] == t) begin
          n_cmp++;
          if (want[pin_sig[i]] != pin_val[i]) begin
            n_bad++;
            $display("FAIL pin_model_%s cyc %0d: got %0d expected %0d", nm[pin_sig[i]], t, want[pin_sig[i]], pin_val[i]);
          end
          n_cmp++;
          if (got[pin_sig[i]] != pin_val[i]) begin
            n_bad++;
            $display("FAIL pin_dut_%s cyc %0d: got %0d expected %0d", nm[pin_sig[i]], t, got[pin_sig[i]], pin_val[i]);
          end
        end
      end
    end
  end

  initial begin
    drive(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // nominal run
    clear_scn();
    st_tab[0] = 1;
    pin(0, 0, 0);  pin(1, 2, 1);  pin(8, 2, 1);  pin(15, 2, 1);
    pin(2, 4, 0);  pin(5, 4, 3);  pin(9, 5, 1);  pin(16, 5, 2);
    pin(14, 6, 0); pin(15, 6, 1); pin(21, 6, 1); pin(4, 7, 1);
    pin(7, 7, 1);  pin(8, 7, 0);  pin(18, 7, 1); pin(21, 1, 0);
    pin(22, 1, 1); pin(23, 0, 0);
    run_scn(0, 26);
    $display("scenario nominal: compared %0d, mismatched %0d", n_cmp, n_bad);

    // stall in stage 0
    clear_scn();
    st_tab[0] = 1; sl_tab[2] = 1; sl_tab[3] = 1;
    pin(3, 4, 1); pin(3, 3, 0); pin(4, 3, 0); pin(5, 3, 1);
    pin(7, 4, 3); pin(7, 3, 1); pin(8, 3, 0); pin(24, 1, 1);
    pin(5, 7, 0); pin(6, 7, 0); pin(7, 7, 1);
    run_scn(0, 28);
    $display("scenario stall: compared %0d, mismatched %0d", n_cmp, n_bad);

    // reset mid-operation, then restart
    clear_scn();
    st_tab[0] = 1; st_tab[10] = 1; rs_tab[10] = 1; st_tab[14] = 1;
    pin(11, 0, 0); pin(11, 5, 0); pin(11, 2, 0); pin(11, 7, 0);
    pin(12, 7, 0); pin(13, 0, 0); pin(15, 2, 1); pin(15, 5, 0);
    pin(36, 1, 1);
    run_scn(0, 40);
    $display("scenario reset: compared %0d, mismatched %0d", n_cmp, n_bad);

    // start held high throughout
    clear_scn();
    for (int e = 0; e < 30; e++) st_tab[e] = 1;
    pin(1, 0, 1); pin(8, 2, 1); pin(22, 1, 1); pin(23, 0, 0);
    pin(23, 5, 2); pin(24, 2, 1); pin(24, 5, 0);
    run_scn(0, 30);
    $display("scenario start_held: compared %0d, mismatched %0d", n_cmp, n_bad);

    // degenerate parameters on the second instance
    clear_scn();
    st_tab[0] = 1;
    pin(1, 2, 1); pin(1, 6, 1); pin(2, 3, 1); pin(2, 4, 0);
    pin(2, 7, 0); pin(3, 6, 1); pin(3, 7, 1); pin(4, 1, 1);
    pin(4, 6, 0); pin(5, 0, 0);
    run_scn(1, 8);
    $display("scenario degenerate: compared %0d, mismatched %0d", n_cmp, n_bad);

    // rst and start together
    clear_scn();
    st_tab[0] = 1; rs_tab[0] = 1;
    pin(1, 0, 0); pin(1, 2, 0); pin(2, 0, 0);
    run_scn(0, 6);
    $display("scenario rst_and_start: compared %0d, mismatched %0d", n_cmp, n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
